mc_pad_arb: RTL and testbench
=============================

// Module: mc_pad_arb
// PURPOSE
// - Shares one bidirectional IO pad (mc_pad_io / _pu / _pd) between NumReq on-chip requesters.
// - Round-robin ownership arbitration with optional hold-time preemption.
// - Enforces a forced-tristate bus turnaround on every ownership change.
// - Registers the pad-side d/oe drive, and synchronises pad input data back to all requesters.
// - Sits between peripheral muxing and the pad ring wrapper.
// PARAMETERS
// NumReq      4  number of requesters (>=2)
// TurnCycles  2  cycles pad_oe_o is forced 0 between owners (>=1)
// MaxHold     0  max OWNED cycles while others wait; 0 = no preemption
// SyncStages  2  flops on pad input path (>=1)
// PORTS
// clk_i      in   1                   clock
// rst_i      in   1                   synchronous reset, active-high
// req_i      in   NumReq              level request; held high while ownership wanted
// d_i        in   NumReq              per-requester output data
// oe_i       in   NumReq              per-requester output enable
// gnt_o      out  NumReq              one-hot grant (all-zero when no owner)
// owner_o    out  $clog2(NumReq)      index of current/pending owner
// busy_o     out  1                   state != IDLE
// rd_o       out  1                   synchronised pad input, broadcast to all
// pad_d_o    out  1                   to pad d_i
// pad_oe_o   out  1                   to pad oe_i (1 = drive)
// pad_d_i    in   1                   from pad d_o
// BEHAVIOUR
// - Reset (rst_i high at edge): state IDLE, rr_ptr=0, owner=0, hold_cnt=0; all sync flops 0.
//   gnt_o=0, busy_o=0, pad_oe_o=0, pad_d_o=0, rd_o=0. Reset mid-ownership drops the grant immediately.
// - Winner selection: first requester with req_i high at or after rr_ptr, wrapping NumReq-1 -> 0.
//   On entry to OWNED, rr_ptr <= owner+1 (mod NumReq).
// - FSM states IDLE, TURN and OWNED:
//   IDLE: if any req_i, latch winner into owner, turn_cnt <= TurnCycles, go TURN.
//   TURN: pad_oe_o=0, gnt_o=0; turn_cnt decrements each edge.
//     At turn_cnt==1, go OWNED and clear hold_cnt.
//     Owner may change in TURN: if req_i[owner] drops, re-select; turn_cnt is not reloaded.
//     If no request remains, go IDLE.
//   OWNED: gnt_o[owner]=1 (decoded from state); hold_cnt increments, saturating.
//     req_i[owner]=0 at edge: if another req_i is pending, select a winner and go TURN; else go IDLE.
//     Preempt (MaxHold>0): if hold_cnt==MaxHold-1 and another requester is pending at the edge,
//     select a winner excluding the current owner and go TURN, even if req_i[owner] is still high.
// - Grant latency: req seen in IDLE at edge E0 -> gnt_o high after edge E0+TurnCycles.
// - Pad drive is registered at every edge:
//   pad_oe_o <= (state==OWNED && next_state==OWNED) ? oe_i[owner] : 0.
//   pad_d_o  <= (state==OWNED && next_state==OWNED) ? d_i[owner]  : 0.
//   - First OWNED cycle: pad_oe_o is still 0.
//   - oe_i/d_i -> pad latency is 1 cycle.
//   - pad_oe_o falls in the same cycle gnt_o falls, so the old and new owner never overlap.
// - Non-owner d_i/oe_i are ignored. gnt_o is never asserted for a requester whose req_i is low at grant time.
// - rd_o is pad_d_i through a SyncStages-flop chain, SyncStages-cycle latency, independent of the FSM.
// - owner_o is valid whenever busy_o=1; it holds its last value in IDLE.
// TESTING
// 1. Reset: hold rst_i 3 cycles with req_i=4'b1111 -> gnt_o=0, pad_oe_o=0, busy_o=0, rd_o=0 throughout.
// 2. Single grant: req_i=4'b0100 at E0 -> gnt_o=4'b0100 after E2 (TurnCycles=2).
//    oe_i[2]=1, d_i[2]=1 -> pad_oe_o=1, pad_d_o=1 one cycle later.
// 3. Round-robin: req_i=4'b1111 held, each owner releases after 5 OWNED cycles
//    -> grant order 0,1,2,3,0.
//    Exactly 2 cycles of pad_oe_o=0 with gnt_o=0 between consecutive owners.
// 4. Preemption: MaxHold=8, req 0 granted and never released, req 3 raised
//    -> gnt_o[0] drops after 8 OWNED cycles; 2 TURN cycles later gnt_o=4'b1000.
// 5. Turnaround abort: req 1 drops during TURN, req 2 pending -> owner_o=2.
//    TURN is not lengthened; gnt_o=4'b0100 at the originally scheduled edge.
// 6. Reset mid-OWNED with pad_oe_o=1 -> pad_oe_o=0, gnt_o=0 next cycle.
//    rd_o tracks pad_d_i toggles with exactly SyncStages=2 cycles delay.

Source files
------------

// File: rtl/mc_pad_arb.sv
// Shares one bidirectional IO pad between NumReq requesters: round-robin ownership,
// optional hold-time preemption, forced-tristate turnaround and a pad input synchroniser.
//
// state | meaning
// IDLE  | no owner, pad released
// TURN  | owner chosen, pad forced tristate for TurnCycles cycles
// OWNED | owner granted, its d/oe drive the pad one cycle later
module mc_pad_arb #(
    parameter int NumReq     = 4,
    parameter int TurnCycles = 2,
    parameter int MaxHold    = 0,
    parameter int SyncStages = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumReq-1:0]         req_i,
    input  logic [NumReq-1:0]         d_i,
    input  logic [NumReq-1:0]         oe_i,
    output logic [NumReq-1:0]         gnt_o,
    output logic [$clog2(NumReq)-1:0] owner_o,
    output logic                      busy_o,
    output logic                      rd_o,
    output logic                      pad_d_o,
    output logic                      pad_oe_o,
    input  logic                      pad_d_i
);

    localparam int OwnW  = $clog2(NumReq);
    localparam int TurnW = $clog2(TurnCycles + 1);
    localparam int HoldW = (MaxHold > 1) ? $clog2(MaxHold) : 1;

    localparam logic [TurnW-1:0] TurnLoad = TurnW'(TurnCycles);
    // hold_cnt stops at MaxHold-1 so a requester arriving late still preempts promptly
    localparam logic [HoldW-1:0] HoldTop  = (MaxHold > 0) ? HoldW'(MaxHold - 1) : {HoldW{1'b1}};
    localparam logic [OwnW-1:0]  LastIdx  = OwnW'(NumReq - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TURN  = 2'd1;
    localparam logic [1:0] OWNED = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [OwnW-1:0]   owner, owner_nxt;
    logic [OwnW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [TurnW-1:0]  turn_cnt, turn_cnt_nxt;
    logic [HoldW-1:0]  hold_cnt, hold_cnt_nxt;
    logic [NumReq-1:0] owner_oh;
    logic [NumReq-1:0] others;
    logic [NumReq-1:0] arb_req;
    logic [OwnW-1:0]   win_idx;
    logic              win_vld;
    logic              preempt;
    logic              stay;
    logic [SyncStages-1:0] sync_q;

    assign owner_oh = NumReq'(1) << owner;
    assign others   = req_i & ~owner_oh;
    assign arb_req  = (state == IDLE) ? req_i : others;
    assign preempt  = (MaxHold > 0) && (hold_cnt == HoldTop) && (|others);
    assign stay     = (state == OWNED) && (state_nxt == OWNED);

    always_comb begin : arbiter
        logic [OwnW-1:0] idx;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = rr_ptr;
        for (int i = 0; i < NumReq; i++) begin
            if (!win_vld && arb_req[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
            idx = (idx == LastIdx) ? '0 : idx + OwnW'(1);
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        rr_ptr_nxt   = rr_ptr;
        turn_cnt_nxt = turn_cnt;
        hold_cnt_nxt = hold_cnt;
        case (state)
            IDLE: begin
                if (|req_i) begin
                    owner_nxt    = win_idx;
                    turn_cnt_nxt = TurnLoad;
                    state_nxt    = TURN;
                end
            end
            TURN: begin
                if (!(|req_i)) begin
                    state_nxt = IDLE;
                end else begin
                    // a withdrawn owner is replaced without restarting the turnaround
                    if (!req_i[owner]) begin
                        owner_nxt = win_idx;
                    end
                    if (turn_cnt == TurnW'(1)) begin
                        state_nxt    = OWNED;
                        hold_cnt_nxt = '0;
                        rr_ptr_nxt   = (owner_nxt == LastIdx) ? '0 : owner_nxt + OwnW'(1);
                    end else begin
                        turn_cnt_nxt = turn_cnt - TurnW'(1);
                    end
                end
            end
            OWNED: begin
                if (!req_i[owner] || preempt) begin
                    if (|others) begin
                        owner_nxt    = win_idx;
                        turn_cnt_nxt = TurnLoad;
                        state_nxt    = TURN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (hold_cnt != HoldTop) begin
                    hold_cnt_nxt = hold_cnt + HoldW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            turn_cnt <= '0;
            hold_cnt <= '0;
            pad_oe_o <= 1'b0;
            pad_d_o  <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            turn_cnt <= turn_cnt_nxt;
            hold_cnt <= hold_cnt_nxt;
            // drive drops on the same edge the grant does, so owners never overlap
            pad_oe_o <= stay ? oe_i[owner] : 1'b0;
            pad_d_o  <= stay ? d_i[owner]  : 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= (sync_q << 1) | SyncStages'(pad_d_i);
        end
    end

    assign rd_o    = sync_q[SyncStages-1];
    assign gnt_o   = (state == OWNED) ? owner_oh : '0;
    assign busy_o  = (state != IDLE);
    assign owner_o = owner;

endmodule

// File: tb/tb_mc_pad_arb.sv
// Bench for mc_pad_arb: directed vector table, hand sequences for multi-cycle corners,
// and randomized traffic against a behavioural ownership model.
module tb_mc_pad_arb;

    localparam int N  = 4;
    localparam int TC = 2;
    localparam int MH = 8;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] d   = '0;
    logic [3:0] oe  = '0;
    logic       pad_in = 1'b0;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy, rd, pad_d, pad_oe;

    always #5 clk = ~clk;

    mc_pad_arb #(.NumReq(N), .TurnCycles(TC), .MaxHold(MH), .SyncStages(SS)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .d_i(d), .oe_i(oe),
        .gnt_o(gnt), .owner_o(owner), .busy_o(busy), .rd_o(rd),
        .pad_d_o(pad_d), .pad_oe_o(pad_oe), .pad_d_i(pad_in)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model: who is busy/granted, how long the gap and hold have lasted
    bit m_busy = 0, m_granted = 0, m_pad_oe = 0, m_pad_d = 0;
    int m_owner = 0, m_ptr = 0, m_gap = 0, m_held = 0;
    bit hist [SS];

    function automatic bit has(input logic [3:0] r, input int idx);
        return ((r >> idx) & 4'd1) != 4'd0;
    endfunction

    function automatic int pick(input logic [3:0] r, input int from, input int excl);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (from + k) % N;
            if (has(r, idx) && idx != excl) return idx;
        end
        return -1;
    endfunction

    task automatic model_step();
        bit stay;
        logic [3:0] oth;
        stay = 0;
        if (rst) begin
            m_busy = 0; m_granted = 0; m_owner = 0; m_ptr = 0; m_gap = 0; m_held = 0;
            for (int k = 0; k < SS; k++) hist[k] = 0;
        end else begin
            if (!m_busy) begin
                if (req != 0) begin
                    m_owner = pick(req, m_ptr, -1); m_busy = 1; m_granted = 0; m_gap = 0;
                end
            end else if (!m_granted) begin
                if (req == 0) m_busy = 0;
                else begin
                    if (!has(req, m_owner)) m_owner = pick(req, m_ptr, -1);
                    m_gap++;
                    if (m_gap == TC) begin
                        m_granted = 1; m_held = 0; m_ptr = (m_owner + 1) % N;
                    end
                end
            end else begin
                oth = req & ~(4'd1 << m_owner);
                if (!has(req, m_owner) || (m_held >= MH - 1 && oth != 0)) begin
                    m_granted = 0;
                    if (oth != 0) begin
                        m_owner = pick(oth, m_ptr, m_owner); m_gap = 0;
                    end else m_busy = 0;
                end else begin
                    stay = 1; m_held++;
                end
            end
            for (int k = SS - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = pad_in;
        end
        m_pad_oe = stay && has(oe, m_owner);
        m_pad_d  = stay && has(d, m_owner);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("gnt", gnt, m_granted ? (32'd1 << m_owner) : 32'd0);
        check("busy", busy, m_busy);
        check("owner", owner, m_owner);
        check("pad_oe", pad_oe, m_pad_oe);
        check("pad_d", pad_d, m_pad_d);
        check("rd", rd, hist[SS-1]);
    endtask

    task automatic do_reset();
        rst = 1; req = '0; d = '0; oe = '0;
        tick(); tick();
        rst = 0;
    endtask

    typedef struct {
        bit rst; logic [3:0] req, d, oe; bit pad;
        logic [3:0] gnt; bit busy, poe, pd, rd;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int guard, gap, held;
        int exp_order [5];
        logic [9:0] pat;

        tbl[0] = '{1, 4'hF, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 0};
        tbl[1] = '{1, 4'hF, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 0};
        tbl[2] = '{1, 4'hF, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 0};
        tbl[3] = '{0, 4'h4, 4'h4, 4'h4, 1, 4'h0, 1, 0, 0, 0};
        tbl[4] = '{0, 4'h4, 4'h4, 4'h4, 1, 4'h0, 1, 0, 0, 1};
        tbl[5] = '{0, 4'h4, 4'h4, 4'h4, 0, 4'h4, 1, 0, 0, 1};
        tbl[6] = '{0, 4'h4, 4'h4, 4'h4, 1, 4'h4, 1, 1, 1, 0};
        tbl[7] = '{0, 4'h4, 4'h0, 4'h4, 0, 4'h4, 1, 1, 0, 1};
        tbl[8] = '{0, 4'h0, 4'h0, 4'h4, 0, 4'h0, 0, 0, 0, 0};

        for (int i = 0; i < 9; i++) begin
            rst = tbl[i].rst; req = tbl[i].req; d = tbl[i].d; oe = tbl[i].oe; pad_in = tbl[i].pad;
            tick();
            check($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            check($sformatf("tbl%0d_pad_oe", i), pad_oe, tbl[i].poe);
            check($sformatf("tbl%0d_pad_d", i), pad_d, tbl[i].pd);
            check($sformatf("tbl%0d_rd", i), rd, tbl[i].rd);
        end

        // round robin with each owner releasing after five owned cycles
        exp_order = '{0, 1, 2, 3, 0};
        do_reset();
        req = 4'hF; oe = 4'hF; d = 4'h5;
        for (int g = 0; g < 5; g++) begin
            gap = 0; guard = 0;
            do begin
                tick();
                guard++;
                req = 4'hF;
                if (gnt == 0) gap++;
            end while (gnt == 0 && guard < 20);
            check("rr_grant_seen", gnt != 0, 1);
            check("rr_gap", gap, 2);
            check($sformatf("rr_order%0d", g), gnt, 32'd1 << exp_order[g]);
            for (int k = 0; k < 4; k++) tick();
            req = 4'hF & ~gnt;
        end

        // preemption after MaxHold owned cycles
        do_reset();
        req = 4'b0001; guard = 0;
        while (gnt != 4'b0001 && guard < 10) begin tick(); guard++; end
        check("pre_grant0", gnt, 4'b0001);
        req = 4'b1001; held = 1; guard = 0;
        while (gnt == 4'b0001 && guard < 30) begin
            tick(); guard++;
            if (gnt == 4'b0001) held++;
        end
        check("pre_hold", held, MH);
        gap = (gnt == 0) ? 1 : 0; guard = 0;
        while (gnt == 0 && guard < 10) begin
            tick(); guard++;
            if (gnt == 0) gap++;
        end
        check("pre_gap", gap, 2);
        check("pre_grant3", gnt, 4'b1000);

        // turnaround abort: owner swapped mid-TURN, grant edge unchanged
        do_reset();
        req = 4'b0010; tick();
        check("abort_owner1", owner, 1);
        req = 4'b0100; tick();
        check("abort_owner2", owner, 2);
        check("abort_gnt_mid", gnt, 4'b0000);
        tick();
        check("abort_gnt", gnt, 4'b0100);

        // reset mid-ownership while driving the pad
        oe = 4'b0100; d = 4'b0100; tick();
        check("rst_mid_oe_pre", pad_oe, 1);
        rst = 1; tick();
        check("rst_mid_oe", pad_oe, 0);
        check("rst_mid_gnt", gnt, 0);
        rst = 0; req = 0;

        // synchroniser latency
        pat = 10'b1011001101;
        for (int i = 0; i < 10; i++) begin
            pad_in = pat[i];
            tick();
            if (i >= SS - 1) check("sync_rd", rd, pat[i - (SS - 1)]);
        end

        // randomized traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            d = 4'($urandom); oe = 4'($urandom); pad_in = 1'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
